// File: rtl/imem_loader_if.sv
// Byte-link and instruction-RAM write-port signals of the program loader.
// master = host/RAM side, slave = loader side.
interface imem_loader_if #(
  parameter int DATA_WIDTH = 32
);
  logic [7:0]            byte_data;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  wr_en;
  logic [31:0]           wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    output byte_data, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  byte_data, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: packs bytes little-endian into words
// written from BASE_ADDR upward. `define LOADER_CHECKSUM_EN adds a word checksum.
module imem_loader #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 64,
  parameter logic [31:0] BASE_ADDR  = 32'h0040_0000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        finish,
  imem_loader_if.slave                bus,
  output logic [$clog2(ADDR_WIDTH):0] word_count,
  output logic                        busy,
  output logic                        done,
  output logic                        full,
  output logic [31:0]                 checksum
);
  localparam int CW = $clog2(ADDR_WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(ADDR_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] asm_word;
  logic [1:0]            bidx;
  logic [CW-1:0]         cnt;
  logic [31:0]           addr;
  logic                  full_q;
  logic                  fin_pend;
  logic                  clear, accept, wr_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    clear   = 1'b0;
    accept  = 1'b0;
    wr_done = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          clear   = 1'b1;
          state_n = COLLECT;
        end
      end
      COLLECT: begin
        accept = bus.byte_valid;
        // A completing byte wins over finish: the word is written, then DONE via fin_pend.
        if (accept && bidx == 2'd3)            state_n = WRITE;
        else if (finish && !accept && bidx == 2'd0) state_n = DONE;
        else if (finish)                       state_n = WRITE;
      end
      WRITE: begin
        wr_done = 1'b1;
        if (cnt == LAST || fin_pend) state_n = DONE;
        else                         state_n = COLLECT;
      end
      default: state_n = IDLE;
    endcase
  end

  // asm_word is zeroed after every write, so a partial word already has zero upper bytes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      asm_word <= '0;
      bidx     <= '0;
      cnt      <= '0;
      addr     <= BASE_ADDR;
      full_q   <= 1'b0;
      fin_pend <= 1'b0;
    end else begin
      if (clear) begin
        asm_word <= '0;
        bidx     <= '0;
        cnt      <= '0;
        addr     <= BASE_ADDR;
        full_q   <= 1'b0;
        fin_pend <= 1'b0;
      end
      if (state == COLLECT) begin
        fin_pend <= finish;
        if (accept) begin
          asm_word[{bidx, 3'b000} +: 8] <= bus.byte_data;
          bidx                          <= bidx + 2'd1;
        end
      end
      if (wr_done) begin
        cnt      <= cnt + CW'(1);
        addr     <= addr + 32'd4;
        bidx     <= '0;
        asm_word <= '0;
        if (cnt == LAST) full_q <= 1'b1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] csum;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       csum <= '0;
    else if (clear)   csum <= '0;
    else if (wr_done) csum <= csum + 32'(asm_word);
  end
  assign checksum = csum;
`else
  assign checksum = '0;
`endif

  assign bus.byte_ready = (state == COLLECT);
  assign bus.wr_en      = (state == WRITE);
  assign bus.wr_addr    = addr;
  assign bus.wr_data    = asm_word;
  assign word_count     = cnt;
  assign busy           = (state == COLLECT) || (state == WRITE);
  assign done           = (state == DONE);
  assign full           = full_q;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader (ADDR_WIDTH=4); expected words come from a
// byte-packing model and are popped on every wr_en cycle.
module tb_imem_loader;
  localparam int          AW   = 4;
  localparam logic [31:0] BASE = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        finish = 1'b0;
  logic [2:0]  word_count;
  logic        busy, done, full;
  logic [31:0] checksum;

  imem_loader_if #(.DATA_WIDTH(32)) bus ();

  imem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .finish     (finish),
    .bus        (bus),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .full       (full),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] sb[$];
  logic [31:0] mw, maddr, mcsum;
  int          mi, mcount;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_start();
    mw = '0; mi = 0; maddr = BASE; mcsum = '0; mcount = 0;
  endfunction

  function automatic void push_word();
    sb.push_back({maddr, mw});
    mcsum  = mcsum + mw;
    maddr  = maddr + 32'd4;
    mcount = mcount + 1;
    mw     = '0;
    mi     = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    mw[8*mi +: 8] = b;
    mi = mi + 1;
    if (mi == 4) push_word();
  endfunction

  function automatic logic [31:0] exp_csum();
`ifdef LOADER_CHECKSUM_EN
    return mcsum;
`else
    return 32'd0;
`endif
  endfunction

  // Write-port monitor: pops the scoreboard on every write cycle.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      logic [63:0] e;
      check("rdy_during_wr", bus.byte_ready, 1'b0);
      check("sb_has_entry", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("wr_addr", bus.wr_addr, e[63:32]);
        check("wr_data", bus.wr_data, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (bus.byte_ready !== 1'b1 && n < 50) begin tick(); n++; end
    ok = (n < 50);
    if (!ok) check("ready_timeout", 1'b0, 1'b1);
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
    model_start();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit fin);
    bit ok;
    bus.byte_data  = b;
    bus.byte_valid = 1'b1;
    wait_ready(ok);
    if (ok) begin
      finish = fin;
      tick();
      finish = 1'b0;
      model_byte(b);
      if (fin && mi != 0) push_word();
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic do_finish();
    bit ok;
    wait_ready(ok);
    if (ok) begin
      finish = 1'b1; tick(); finish = 1'b0;
      if (mi != 0) push_word();
    end
  endtask

  task automatic wait_done(input int exp_cnt, input bit exp_full);
    int n = 0;
    while (done !== 1'b1 && n < 50) begin tick(); n++; end
    check("done", done, 1'b1);
    check("word_count", word_count, exp_cnt);
    check("full", full, exp_full);
    check("checksum", checksum, exp_csum());
    check("ready_in_done", bus.byte_ready, 1'b0);
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    logic [7:0] w1 [8] = '{8'h13, 8'h00, 8'h08, 8'h3C, 8'h00, 8'h00, 8'h09, 8'h24};
    int acc, idx, cyc;
    bit rdy;
    bus.byte_data = '0; bus.byte_valid = 1'b0;
    model_start();
    #2 reset = 1'b0;
    #1;
    check("rst_wr_en", bus.wr_en, 1'b0);
    check("rst_ready", bus.byte_ready, 1'b0);
    check("rst_wr_addr", bus.wr_addr, BASE);
    check("rst_wr_data", bus.wr_data, 32'd0);
    check("rst_count", word_count, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_full", full, 1'b0);
    check("rst_csum", checksum, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();

    // Two full words, then finish on a word boundary
    do_start();
    for (int i = 0; i < 8; i++) begin
      send_byte(w1[i], 1'b0);
      if (i == 3) check("lat_word", bus.wr_en, 1'b1);
    end
    do_finish();
    wait_done(2, 1'b0);

    // Restart from DONE; partial word with a start pulse ignored mid-COLLECT
    do_start();
    check("restart_done", done, 1'b0);
    check("restart_count", word_count, 0);
    check("restart_busy", busy, 1'b1);
    send_byte(8'hAA, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    send_byte(8'hBB, 1'b0);
    do_finish();
    check("lat_partial", bus.wr_en, 1'b1);
    wait_done(1, 1'b0);

    // Stalled handshake, finish coinciding with the 4th byte
    do_start();
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      send_byte(8'(8'h5A + 8'(i * 17)), i == 3);
    end
    check("lat_fin4", bus.wr_en, 1'b1);
    wait_done(1, 1'b0);

    // Reset asserted the cycle after the 2nd byte of word 1
    do_start();
    for (int i = 0; i < 6; i++) send_byte(8'(8'h11 * (i + 1)), 1'b0);
    reset = 1'b0;
    #1;
    check("mid_rst_wr_en", bus.wr_en, 1'b0);
    check("mid_rst_ready", bus.byte_ready, 1'b0);
    check("mid_rst_addr", bus.wr_addr, BASE);
    check("mid_rst_data", bus.wr_data, 32'd0);
    check("mid_rst_count", word_count, 0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_csum", checksum, 32'd0);
    mw = '0; mi = 0;
    tick();
    reset = 1'b1;
    tick();
    do_start();
    check("post_rst_count", word_count, 0);
    for (int i = 0; i < 4; i++) send_byte(8'(8'hC0 + i), 1'b0);
    do_finish();
    wait_done(1, 1'b0);

    // Overflow: 20 bytes offered, only 16 fit in AW=4 words
    do_start();
    acc = 0; idx = 0; cyc = 0;
    bus.byte_valid = 1'b1;
    while (cyc < 200 && done !== 1'b1 && idx < 20) begin
      bus.byte_data = 8'(idx + 1);
      rdy = bus.byte_ready;
      tick(); cyc++;
      if (rdy) begin model_byte(8'(idx + 1)); idx++; acc++; end
    end
    wait_done(4, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus.byte_data = 8'(idx + 1);
      if (bus.byte_ready === 1'b1) acc++;
      tick();
    end
    bus.byte_valid = 1'b0;
    check("ovf_accepted", acc, 16);

    check("sb_final", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader that fills the instruction memory at run time, replacing the fixed build-time image. It accepts bytes over a valid/ready handshake, packs them little-endian into 32-bit instruction words, and issues single-cycle word writes at byte addresses starting from the text-segment base 0x400000. Its write address convention matches the instruction-fetch path, so word i lands at memory index (addr − BASE_ADDR) >> 2 = i. It sits between the host byte link (UART receiver) and the write port of the instruction RAM.

## Interface
- DATA_WIDTH, 32, instruction word width; must be 32.
- ADDR_WIDTH, 64, instruction memory depth in words.
- BASE_ADDR, 32'h400000, byte address of word 0.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a load session. Sampled only in IDLE or DONE.
- finish  in  1  pulse; ends the session. Sampled only in COLLECT.
- byte_data  in  8  incoming byte.
- byte_valid  in  1  byte_data is valid.
- byte_ready  out  1  loader can accept a byte.
- wr_en  out  1  instruction memory write strobe, one cycle per word.
- wr_addr  out  32  byte address of the word being written.
- wr_data  out  32  packed instruction word.
- word_count  out  $clog2(ADDR_WIDTH)+1  words written this session.
- busy  out  1  high in COLLECT and WRITE.
- done  out  1  high in DONE.
- full  out  1  session ended because ADDR_WIDTH words were written.
- checksum  out  32  see Configuration.

## Operation
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE: byte_ready=0. On start, clear word_count, byte index, assembly register, full, and checksum. Set the address to BASE_ADDR and go to COLLECT.
- COLLECT: byte_ready=1. A byte is accepted on an edge where byte_valid&byte_ready. Byte k (k=0..3) goes into bits [8k+7:8k], so the first byte is the LSB.
  - After byte 3 is accepted, go to WRITE.
- finish in COLLECT:
  - If the byte index is 0 after this cycle's accept, go to DONE with no write.
  - Otherwise, zero the unfilled upper bytes, go to WRITE, then DONE.
  - When finish and an accepted byte coincide, the byte is included first.
  - If that byte completes the word, the result is one write followed by DONE.
- WRITE: wr_en=1 for exactly one cycle. wr_addr = BASE_ADDR + 4·word_count; wr_data = the assembled word.
  - On the next edge: word_count+1, address+4, byte index 0.
  - If word_count+1 == ADDR_WIDTH, set full=1 and go to DONE.
  - Else if finish was pending, go to DONE.
  - Else go to COLLECT.
- DONE: byte_ready=0. done, full, word_count and checksum are held. start returns to the IDLE-clear behaviour and enters COLLECT on the same edge.
- start in COLLECT or WRITE is ignored. finish outside COLLECT is ignored.
- Address arithmetic is 32-bit, modulo 2^32. It cannot wrap for legal ADDR_WIDTH.

## Timing
- Reset values (async, immediate): state IDLE, byte_ready=0, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, word_count=0, busy=0, done=0, full=0, checksum=0.
- Reset asserted mid-session aborts immediately. A word being written in that cycle is dropped and wr_en falls asynchronously.
- All outputs are registered or decoded from registered state only. byte_ready has no combinational path from byte_valid.
- Latency:
  - wr_en is high the cycle after the 4th byte is accepted.
  - wr_en is high the cycle after finish when the word is partial.
- Peak throughput: 5 cycles per word, since byte_ready=0 during WRITE.
- wr_addr and wr_data are stable for the whole wr_en cycle.

## Configuration
- LOADER_CHECKSUM_EN defined: checksum is a 32-bit modulo-2^32 sum of every wr_data written this session.
  - It is updated on the edge ending each WRITE cycle and cleared on start.
- LOADER_CHECKSUM_EN undefined: the accumulator is not built and checksum is tied to 0.

## Test plan
- Reset, then start, then bytes 13 00 08 3C, 00 00 09 24:
  - wr_en pulses twice.
  - First write: addr 0x400000, data 0x3C080013.
  - Second write: addr 0x400004, data 0x24090000.
  - After finish: done=1, word_count=2.
  - With the macro: checksum=0x60110013.
- Partial word: start, bytes AA BB, then finish:
  - One write at 0x400000 with data 0x0000BBAA.
  - Then done=1, word_count=1.
- Overflow with ADDR_WIDTH=4: stream 20 bytes.
  - Four writes, 0x400000 to 0x40000C.
  - full=1, done=1, byte_ready=0; bytes 17–20 are never accepted.
- Handshake stalls: byte_valid toggled randomly with gaps, and finish asserted together with the 4th byte.
  - Exactly one write with the correct word, then DONE.
  - No byte is accepted while wr_en=1.
- Reset mid-session: assert reset the cycle after the 2nd byte of word 1.
  - All outputs return to their reset values immediately.
  - A following start writes from 0x400000 again with word_count=0.
- Restart from DONE: start loads a new image from 0x400000.
  - done clears and word_count restarts from 0.
  - start pulsed during COLLECT has no effect.
